// File: rtl/wb_openram_arbiter.sv
// Round-robin arbiter sharing port 0 of a single OpenRAM macro between
// NUM_PORTS Wishbone slave ports. Each access runs IDLE -> ISSUE -> WAIT -> ACK.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | pick next requester round-robin, register RAM controls
//   ISSUE   | RAM samples controls at end of cycle (csb0 low unless dropped)
//   WAIT    | RAM output settles; read data captured on the exit edge
//   ACK     | one-cycle ack to the granted port if it still holds cyc
module wb_openram_arbiter #(
   parameter int                   NUM_PORTS     = 2,
   parameter int                   ADDR_WIDTH    = 8,
   parameter logic [NUM_PORTS-1:0] WRITE_EN_MASK = {NUM_PORTS{1'b1}}
) (
   input  logic                              wb_clk_i,
   input  logic                              wb_rst_i,
   input  logic [NUM_PORTS-1:0]              wbs_stb_i,
   input  logic [NUM_PORTS-1:0]              wbs_cyc_i,
   input  logic [NUM_PORTS-1:0]              wbs_we_i,
   input  logic [4*NUM_PORTS-1:0]            wbs_sel_i,
   input  logic [32*NUM_PORTS-1:0]           wbs_dat_i,
   input  logic [(ADDR_WIDTH+2)*NUM_PORTS-1:0] wbs_adr_i,
   output logic [NUM_PORTS-1:0]              wbs_ack_o,
   output logic [32*NUM_PORTS-1:0]           wbs_dat_o,
   output logic                              ram_clk0,
   output logic                              ram_csb0,
   output logic                              ram_web0,
   output logic [3:0]                        ram_wmask0,
   output logic [ADDR_WIDTH-1:0]             ram_addr0,
   output logic [31:0]                       ram_din0,
   input  logic [31:0]                       ram_dout0
);

   localparam int AW2 = ADDR_WIDTH + 2;
   localparam int GW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_ACK   = 2'd3;

   logic [1:0]            state;
   logic [GW-1:0]         grant;
   logic [GW-1:0]         last_grant;
   logic                  grant_we;
   logic [31:0]           dat_q;
   logic [NUM_PORTS-1:0]  req;
   logic [NUM_PORTS-1:0]  ack_vec;
   logic [GW-1:0]         pick;
   logic [GW-1:0]         idx;
   logic                  pick_found;
   logic [ADDR_WIDTH-1:0] pick_addr;
   logic [31:0]           pick_dat;
   logic [3:0]            pick_sel;
   logic                  pick_we;
   logic                  unused_adr_lsbs;

   assign ram_clk0  = wb_clk_i;
   assign wbs_ack_o = ack_vec;
   assign wbs_dat_o = {NUM_PORTS{dat_q}};
   assign req       = wbs_cyc_i & wbs_stb_i & ~ack_vec;

   // Ack follows cyc combinationally so a master that aborts in ACK gets no ack.
   always_comb begin
      ack_vec = '0;
      if (state == ST_ACK) ack_vec[grant] = wbs_cyc_i[grant];
   end

   // Round-robin search starting one past the last served port.
   always_comb begin
      pick_found = 1'b0;
      pick       = last_grant;
      idx        = last_grant;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx = (idx == GW'(NUM_PORTS - 1)) ? '0 : idx + GW'(1);
         if (!pick_found && req[idx]) begin
            pick_found = 1'b1;
            pick       = idx;
         end
      end
   end

   // Mux the picked port's request fields.
   always_comb begin
      pick_addr = '0;
      pick_dat  = '0;
      pick_sel  = '0;
      pick_we   = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (pick == GW'(p)) begin
            pick_addr = wbs_adr_i[p*AW2+2 +: ADDR_WIDTH];
            pick_dat  = wbs_dat_i[p*32 +: 32];
            pick_sel  = wbs_sel_i[p*4 +: 4];
            pick_we   = wbs_we_i[p];
         end
      end
   end

   // Byte-lane bits of the address are meaningless for a word RAM.
   always_comb begin
      unused_adr_lsbs = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++)
         unused_adr_lsbs = unused_adr_lsbs ^ (^wbs_adr_i[p*AW2 +: 2]);
   end

   // Access sequencer; RAM controls are registered so the macro sees clean pins.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state      <= ST_IDLE;
         grant      <= '0;
         last_grant <= GW'(NUM_PORTS - 1);
         grant_we   <= 1'b0;
         dat_q      <= '0;
         ram_csb0   <= 1'b1;
         ram_web0   <= 1'b1;
         ram_wmask0 <= 4'h0;
         ram_addr0  <= '0;
         ram_din0   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_found) begin
                  grant      <= pick;
                  grant_we   <= pick_we;
                  ram_addr0  <= pick_addr;
                  ram_din0   <= pick_dat;
                  ram_web0   <= ~pick_we;
                  ram_wmask0 <= pick_we ? pick_sel : 4'h0;
                  // Writes from protected ports never select the macro but are still acked.
                  ram_csb0   <= pick_we & ~WRITE_EN_MASK[pick];
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               ram_csb0   <= 1'b1;
               ram_web0   <= 1'b1;
               ram_wmask0 <= 4'h0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!grant_we) dat_q <= ram_dout0;
               state <= ST_ACK;
            end
            ST_ACK: begin
               last_grant <= grant;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_openram_arbiter.md
# wb_openram_arbiter

Multi-master successor to the two-port OpenRAM Wishbone wrapper: NUM_PORTS Wishbone slave ports share port 0 (RW) of a single OpenRAM macro. Access is granted by a round-robin arbiter and runs through a registered issue/wait/ack sequencer. Per-port write permission is set by a parameter mask. The block sits between the user-area Wishbone masters (management SoC plus user cores) and the OpenRAM macro, all in the wb_clk_i domain.

## Interface
- NUM_PORTS, 2, number of Wishbone slave ports (2..8)
- ADDR_WIDTH, 8, RAM word-address width; Wishbone byte address is ADDR_WIDTH+2 bits
- WRITE_EN_MASK, all ones (NUM_PORTS bits), bit p=1 means port p may write
- wb_clk_i  in  1  single clock; also drives ram_clk0
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_stb_i  in  NUM_PORTS  strobe, one bit per port
- wbs_cyc_i  in  NUM_PORTS  cycle, one bit per port
- wbs_we_i  in  NUM_PORTS  write enable, one bit per port
- wbs_sel_i  in  4*NUM_PORTS  byte selects; port p occupies [4p+3:4p]
- wbs_dat_i  in  32*NUM_PORTS  write data; port p occupies [32p+31:32p]
- wbs_adr_i  in  (ADDR_WIDTH+2)*NUM_PORTS  byte address; bits [1:0] ignored
- wbs_ack_o  out  NUM_PORTS  one-cycle acknowledge
- wbs_dat_o  out  32*NUM_PORTS  read data; every slice carries the same captured word
- ram_clk0  out  1  equals wb_clk_i
- ram_csb0  out  1  active-low chip select
- ram_web0  out  1  active-low write enable
- ram_wmask0  out  4  byte write mask
- ram_addr0  out  ADDR_WIDTH  word address
- ram_din0  out  32  data to RAM
- ram_dout0  in  32  data from RAM

## Operation
- A port requests when cyc & stb are high and its ack is not asserted in the current cycle.
- State machine with states IDLE, ISSUE, WAIT, ACK.
- IDLE: if any port requests, select a grant g round-robin. Search starts at last_grant+1 and wraps modulo NUM_PORTS. On the same edge, register the RAM controls and go to ISSUE. With no request, stay in IDLE.
- Registered RAM controls at the IDLE->ISSUE edge:
  - ram_addr0 = adr_g[ADDR_WIDTH+1:2]
  - ram_din0 = dat_g
  - ram_web0 = ~we_g
  - ram_wmask0 = we_g ? sel_g : 4'h0
  - ram_csb0 = 0, except a write from a port with WRITE_EN_MASK[g]=0 keeps csb0=1 (write silently dropped, still acked).
- ISSUE: RAM samples controls at the end of this cycle. Then deassert csb0/web0 to 1 and wmask0 to 0; go to WAIT.
- WAIT: on the edge leaving WAIT, capture ram_dout0 into the dat_o register, reads only; writes leave dat_o unchanged. Go to ACK.
- ACK: wbs_ack_o[g]=1 for exactly one cycle, provided wbs_cyc_i[g] is still high. Set last_grant=g and go to IDLE.
- Aborted cycle: if cyc[g] drops in ISSUE/WAIT/ACK, the RAM access completes (not cancelled), ack is suppressed, and last_grant still updates.
- Non-granted requesters stall (no ack) until granted. A port that drops its request before being granted is never serviced.
- Reset: state=IDLE, last_grant=NUM_PORTS-1 (port 0 has first priority), all outputs at their reset values.

## Timing
- Reset values: ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, wbs_ack_o=0, wbs_dat_o=0.
- Latency from an idle block: request sampled at edge 0, csb0 low in cycle 1, ack high in cycle 3. Ack comes 3 cycles after the grant edge.
- Throughput: one access per 4 cycles. A port that holds stb after its ack is re-eligible in the next IDLE but ranks last in round-robin order.
- Simultaneous requests from all ports: grants rotate p, p+1, …; no port waits more than NUM_PORTS-1 accesses.
- Reset asserted mid-access: next edge forces IDLE and csb0=1. The pending ack is never issued and the RAM write may or may not have occurred.
- wbs_dat_o holds its value between reads and is valid only while the matching ack is high.

## Test plan
- Reset: hold wb_rst_i 2 cycles -> csb0=1, web0=1, wmask0=0, all acks 0, dat_o=0.
- Single write then read (NUM_PORTS=3, port 1): write 0xDEADBEEF to byte addr 0x010 with sel=0xF -> ram_addr0=0x04, wmask0=0xF, web0=0 in cycle 1, ack[1] in cycle 3. Read back (model returns the written word) -> dat_o=0xDEADBEEF with ack[1].
- Byte mask: write sel=0x5 -> wmask0=0x5. A read access always drives wmask0=0x0 and web0=1.
- Contention: ports 0, 1, 2 assert stb at the same edge after reset -> grant order 0, 1, 2, with acks in cycles 3, 7, 11. Port 0 re-requesting immediately is served after port 2.
- Write protect (WRITE_EN_MASK=3'b101): port 1 writes -> csb0 stays 1 throughout, ack[1] still in cycle 3. Port 1 reads -> normal RAM access.
- Abort and reset: port 0 drops cyc in WAIT -> no ack, next port granted. Asserting reset in ISSUE -> IDLE next edge, csb0=1, no ack.
